// File: rtl/decode_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// decode_hazard_ctrl
//
// Scoreboard-based issue controller sitting between decode and execute.
// Each architectural register has a small pending-write counter. Decode is
// stalled while a source operand has an outstanding write, or while the
// destination counter is saturated. Writeback releases counters; flush clears
// the whole scoreboard. A watchdog flags hazards that never resolve.
//
// Parameters:
//   NUM_REGS  number of architectural registers (x0 hardwired to zero)
//   CNT_W     pending-write counter width (max in flight = 2^CNT_W-1)
//   TIMEOUT   consecutive STALL cycles before o_hazard_timeout (1..65535)
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_id_valid                decode holds a valid instruction
//   i_id_rs1_addr/_used       source 1 address / instruction reads rs1
//   i_id_rs2_addr/_used       source 2 address / instruction reads rs2
//   i_id_rd_addr              destination register
//   i_id_reg_write            instruction writes rd
//   i_ex_ready                execute can accept an instruction this cycle
//   i_reg_write_wb            writeback commits a register write
//   i_rd_addr_wb              writeback destination
//   i_flush                   kill in-flight work, clear scoreboard
//   o_issue                   instruction accepted into execute this cycle
//   o_id_stall                hold PC / IF-ID registers
//   o_pending_mask            bit i set = register i has an outstanding write
//   o_hazard_timeout          sticky watchdog flag
//   o_stall_cycles            stall event counter
//
// Optional feature macro: HAZ_STATS_EN
//   defined   -> o_stall_cycles counts every cycle with o_id_stall=1 (wraps)
//   undefined -> o_stall_cycles tied to 0, no counter flops
// ---------------------------------------------------------------------------
module decode_hazard_ctrl #(
  parameter  int NUM_REGS = 32,
  parameter  int CNT_W    = 2,
  parameter  int TIMEOUT  = 255,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_id_valid,
  input  logic [AW-1:0]       i_id_rs1_addr,
  input  logic                i_id_rs1_used,
  input  logic [AW-1:0]       i_id_rs2_addr,
  input  logic                i_id_rs2_used,
  input  logic [AW-1:0]       i_id_rd_addr,
  input  logic                i_id_reg_write,
  input  logic                i_ex_ready,
  input  logic                i_reg_write_wb,
  input  logic [AW-1:0]       i_rd_addr_wb,
  input  logic                i_flush,
  output logic                o_issue,
  output logic                o_id_stall,
  output logic [NUM_REGS-1:0] o_pending_mask,
  output logic                o_hazard_timeout,
  output logic [31:0]         o_stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [15:0]      WD_MAX  = 16'(TIMEOUT);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt      [NUM_REGS];
  logic [CNT_W-1:0]    w_cnt_next [NUM_REGS];
  logic [15:0]         r_wdog;
  logic                r_timeout;
  logic                w_hazard;
  logic                w_issue;
  logic                w_id_stall;
  logic [NUM_REGS-1:0] w_mask;

  // Hazard looks only at registered counters: a writeback landing this cycle
  // does not unblock decode until the next cycle.
  always_comb begin
    w_hazard = 1'b0;
    if (i_id_rs1_used && (i_id_rs1_addr != '0) && (r_cnt[i_id_rs1_addr] != '0))
      w_hazard = 1'b1;
    if (i_id_rs2_used && (i_id_rs2_addr != '0) && (r_cnt[i_id_rs2_addr] != '0))
      w_hazard = 1'b1;
    if (i_id_reg_write && (i_id_rd_addr != '0) && (r_cnt[i_id_rd_addr] == CNT_MAX))
      w_hazard = 1'b1;
  end

  // Reset gating keeps issue/stall low while the block is held in reset.
  assign w_issue    = i_rst_n & i_id_valid & i_ex_ready & ~w_hazard &
                      (r_state != ST_FLUSH) & ~i_flush;
  assign w_id_stall = i_rst_n & i_id_valid & ~w_issue;

  // Per-register next count. Simultaneous inc and dec cancel; a writeback to
  // an empty counter (or during FLUSH) is dropped so nothing underflows.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (i != 0) begin
        w_cnt_next[i] = r_cnt[i]
          + CNT_W'(w_issue & i_id_reg_write & (i_id_rd_addr == AW'(i)))
          - CNT_W'(i_reg_write_wb & (i_rd_addr_wb == AW'(i)) &
                   (r_cnt[i] != '0) & (r_state != ST_FLUSH));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 1; i < NUM_REGS; i++) w_mask[i] = (r_cnt[i] != '0);
  end

  // FSM: flush overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (i_id_valid && w_hazard) w_state_next = ST_STALL;
      ST_STALL: if (!w_hazard || !i_id_valid) w_state_next = ST_RUN;
      ST_FLUSH: w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
    if (i_flush) w_state_next = ST_FLUSH;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_RUN;
    else          r_state <= w_state_next;
  end

  // Watchdog counts STALL cycles and saturates at TIMEOUT; the flag rises on
  // the same edge the count reaches TIMEOUT and is held until flush/reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (i_flush) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == ST_STALL) begin
      if (r_wdog < WD_MAX) r_wdog <= r_wdog + 16'd1;
      if (r_wdog >= WD_MAX - 16'd1) r_timeout <= 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_stall_cycles <= '0;
    else if (w_id_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = '0;
`endif

  assign o_issue          = w_issue;
  assign o_id_stall       = w_id_stall;
  assign o_pending_mask   = w_mask;
  assign o_hazard_timeout = r_timeout;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Testbench for decode_hazard_ctrl: directed stimulus with hand-derived
// expectations pushed to a scoreboard queue and checked on the falling edge.
module tb_decode_hazard_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rstN;
  logic        idValid;
  logic [4:0]  rs1Addr;
  logic        rs1Used;
  logic [4:0]  rs2Addr;
  logic        rs2Used;
  logic [4:0]  rdAddr;
  logic        regWrite;
  logic        exReady;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic        flush;
  logic        issue;
  logic        idStall;
  logic [31:0] pendingMask;
  logic        hazardTimeout;
  logic [31:0] stallCycles;

  typedef struct {
    string       tag;
    logic        expIssue;
    logic        expStall;
    logic [31:0] expMask;
    logic        expTimeout;
    logic [31:0] expStats;
  } exp_t;

  exp_t        sbQueue[$];
  int          checkCount = 0;
  int          errorCount = 0;
  int unsigned statsModel = 0;

  decode_hazard_ctrl #(
    .NUM_REGS(32),
    .CNT_W   (2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_id_valid      (idValid),
    .i_id_rs1_addr   (rs1Addr),
    .i_id_rs1_used   (rs1Used),
    .i_id_rs2_addr   (rs2Addr),
    .i_id_rs2_used   (rs2Used),
    .i_id_rd_addr    (rdAddr),
    .i_id_reg_write  (regWrite),
    .i_ex_ready      (exReady),
    .i_reg_write_wb  (wbValid),
    .i_rd_addr_wb    (wbAddr),
    .i_flush         (flush),
    .o_issue         (issue),
    .o_id_stall      (idStall),
    .o_pending_mask  (pendingMask),
    .o_hazard_timeout(hazardTimeout),
    .o_stall_cycles  (stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue what the
  // outputs must look like before the next rising edge.
  task automatic applyStimulus(input string tag,
                               input logic v, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2,
                               input logic [4:0] rd, input logic w, input logic rdy,
                               input logic wbv, input logic [4:0] wba, input logic fl,
                               input logic eIssue, input logic eStall,
                               input logic [31:0] eMask, input logic eTimeout);
    exp_t e;
    @(posedge clk);
    #1;
    idValid  = v;   rs1Addr  = r1;  rs1Used = u1;
    rs2Addr  = r2;  rs2Used  = u2;
    rdAddr   = rd;  regWrite = w;   exReady = rdy;
    wbValid  = wbv; wbAddr   = wba; flush   = fl;
    e.tag        = tag;
    e.expIssue   = eIssue;
    e.expStall   = eStall;
    e.expMask    = eMask;
    e.expTimeout = eTimeout;
`ifdef HAZ_STATS_EN
    e.expStats   = statsModel;
`else
    e.expStats   = 32'd0;
`endif
    if (eStall) statsModel++;
    sbQueue.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbQueue.size() != 0) begin
      exp_t e;
      e = sbQueue.pop_front();
      checkOutput({e.tag, ".issue"},   32'(issue),         32'(e.expIssue));
      checkOutput({e.tag, ".stall"},   32'(idStall),       32'(e.expStall));
      checkOutput({e.tag, ".mask"},    pendingMask,        e.expMask);
      checkOutput({e.tag, ".timeout"}, 32'(hazardTimeout), 32'(e.expTimeout));
      checkOutput({e.tag, ".stats"},   stallCycles,        e.expStats);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rstN = 1'b0;
    idValid = 0; rs1Addr = 0; rs1Used = 0; rs2Addr = 0; rs2Used = 0;
    rdAddr = 0; regWrite = 0; exReady = 0; wbValid = 0; wbAddr = 0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset.issue",   32'(issue),         32'd0);
    checkOutput("reset.stall",   32'(idStall),       32'd0);
    checkOutput("reset.mask",    pendingMask,        32'd0);
    checkOutput("reset.timeout", 32'(hazardTimeout), 32'd0);
    checkOutput("reset.stats",   stallCycles,        32'd0);
    rstN = 1'b1;

    // RAW on x5, released by writeback one cycle late
    applyStimulus("raw.wr5",  1, 0,0, 0,0, 5,1, 1, 0,0, 0, 1,0, 32'h0,  0);
    applyStimulus("raw.rd5a", 1, 5,1, 0,0, 0,0, 1, 0,0, 0, 0,1, 32'h20, 0);
    applyStimulus("raw.rd5b", 1, 5,1, 0,0, 0,0, 1, 1,5, 0, 0,1, 32'h20, 0);
    applyStimulus("raw.rd5c", 1, 5,1, 0,0, 0,0, 1, 0,0, 0, 1,0, 32'h0,  0);

    // Saturation of x7 (three in flight), then drain and no underflow
    applyStimulus("sat.wr1",  1, 0,0, 0,0, 7,1, 1, 0,0, 0, 1,0, 32'h0,  0);
    applyStimulus("sat.wr2",  1, 0,0, 0,0, 7,1, 1, 0,0, 0, 1,0, 32'h80, 0);
    applyStimulus("sat.wr3",  1, 0,0, 0,0, 7,1, 1, 0,0, 0, 1,0, 32'h80, 0);
    applyStimulus("sat.wr4a", 1, 0,0, 0,0, 7,1, 1, 0,0, 0, 0,1, 32'h80, 0);
    applyStimulus("sat.wr4b", 1, 0,0, 0,0, 7,1, 1, 1,7, 0, 0,1, 32'h80, 0);
    applyStimulus("sat.wr4c", 1, 0,0, 0,0, 7,1, 1, 0,0, 0, 1,0, 32'h80, 0);
    applyStimulus("sat.full", 1, 0,0, 0,0, 7,1, 1, 0,0, 0, 0,1, 32'h80, 0);
    applyStimulus("sat.wb1",  0, 0,0, 0,0, 0,0, 1, 1,7, 0, 0,0, 32'h80, 0);
    applyStimulus("sat.wb2",  0, 0,0, 0,0, 0,0, 1, 1,7, 0, 0,0, 32'h80, 0);
    applyStimulus("sat.wb3",  0, 0,0, 0,0, 0,0, 1, 1,7, 0, 0,0, 32'h80, 0);
    applyStimulus("sat.wb4",  0, 0,0, 0,0, 0,0, 1, 1,7, 0, 0,0, 32'h0,  0);
    applyStimulus("sat.idle", 0, 0,0, 0,0, 0,0, 1, 0,0, 0, 0,0, 32'h0,  0);

    // Simultaneous inc and dec on x3
    applyStimulus("sim.wr3",  1, 0,0, 0,0, 3,1, 1, 0,0, 0, 1,0, 32'h0, 0);
    applyStimulus("sim.both", 1, 0,0, 0,0, 3,1, 1, 1,3, 0, 1,0, 32'h8, 0);
    applyStimulus("sim.hold", 0, 0,0, 0,0, 0,0, 1, 0,0, 0, 0,0, 32'h8, 0);
    applyStimulus("sim.wb3",  0, 0,0, 0,0, 0,0, 1, 1,3, 0, 0,0, 32'h8, 0);
    applyStimulus("sim.done", 0, 0,0, 0,0, 0,0, 1, 0,0, 0, 0,0, 32'h0, 0);

    // x0 is never tracked
    for (int k = 0; k < 5; k++)
      applyStimulus("x0", 1, 0,1, 0,1, 0,1, 1, (k == 2),0, 0, 1,0, 32'h0, 0);

    // Back-pressure stall: no hazard, execute not ready
    applyStimulus("bp.a", 1, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,1, 32'h0, 0);
    applyStimulus("bp.b", 1, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,1, 32'h0, 0);

    // Flush beats issue, one FLUSH cycle, then issue resumes
    applyStimulus("fl.kill", 1, 0,0, 0,0, 4,1, 1, 0,0, 1, 0,1, 32'h0,  0);
    applyStimulus("fl.hold", 1, 0,0, 0,0, 4,1, 1, 1,4, 0, 0,1, 32'h0,  0);
    applyStimulus("fl.go",   1, 0,0, 0,0, 4,1, 1, 0,0, 0, 1,0, 32'h0,  0);
    applyStimulus("fl.chk",  0, 0,0, 0,0, 0,0, 1, 0,0, 0, 0,0, 32'h10, 0);
    applyStimulus("fl.wb4",  0, 0,0, 0,0, 0,0, 1, 1,4, 0, 0,0, 32'h10, 0);

    // Watchdog: flag visible once TIMEOUT full STALL cycles have elapsed
    applyStimulus("wd.wr9",   1, 0,0, 0,0, 9,1, 1, 0,0, 0, 1,0, 32'h0,   0);
    applyStimulus("wd.enter", 1, 0,0, 9,1, 0,0, 1, 0,0, 0, 0,1, 32'h200, 0);
    for (int k = 1; k <= TIMEOUT + 5; k++)
      applyStimulus("wd.hold", 1, 0,0, 9,1, 0,0, 1, 0,0, 0, 0,1, 32'h200, (k > TIMEOUT));
    applyStimulus("wd.flush", 1, 0,0, 9,1, 0,0, 1, 0,0, 1, 0,1, 32'h200, 1);
    applyStimulus("wd.fcyc",  1, 0,0, 9,1, 0,0, 1, 0,0, 0, 0,1, 32'h0,   0);
    applyStimulus("wd.resume",1, 0,0, 9,1, 0,0, 1, 0,0, 0, 1,0, 32'h0,   0);

    // Asynchronous reset in the middle of a stall
    applyStimulus("rst.wr6",  1, 0,0, 0,0, 6,1, 1, 0,0, 0, 1,0, 32'h0,  0);
    applyStimulus("rst.rd6a", 1, 6,1, 0,0, 0,0, 1, 0,0, 0, 0,1, 32'h40, 0);
    applyStimulus("rst.rd6b", 1, 6,1, 0,0, 0,0, 1, 0,0, 0, 0,1, 32'h40, 0);
    @(negedge clk);
    #2;
    rstN = 1'b0;
    statsModel = 0;
    #1;
    checkOutput("rstMid.issue",   32'(issue),         32'd0);
    checkOutput("rstMid.stall",   32'(idStall),       32'd0);
    checkOutput("rstMid.mask",    pendingMask,        32'd0);
    checkOutput("rstMid.timeout", 32'(hazardTimeout), 32'd0);
    checkOutput("rstMid.stats",   stallCycles,        32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus("rst.after", 1, 6,1, 0,0, 0,0, 1, 0,0, 0, 1,0, 32'h0, 0);
    applyStimulus("rst.bp",    1, 6,1, 0,0, 0,0, 0, 0,0, 0, 0,1, 32'h0, 0);
    applyStimulus("rst.end",   0, 0,0, 0,0, 0,0, 1, 0,0, 0, 0,0, 32'h0, 0);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("sbDrain", 32'(sbQueue.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
